acc_filter_scan: RTL



---
 rtl/acc_filter_scan.sv | 119 +++++++++++
 1 files changed

// File: rtl/acc_filter_scan.sv
// Sequential acceptance-filter scan: walks NOBJ message objects through one masked
// compare and reports the lowest matching index. Optional macro ACCF_IDE_MATCH_EN
// additionally requires the object's IDE flag to equal the received frame's.
module acc_filter_scan #(
  parameter int NOBJ = 8,
  parameter int IDXW = 3
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [28:0]     rx_id,
  input  logic            rx_ext,
  output logic [IDXW-1:0] obj_sel,
  input  logic [28:0]     obj_id,
  input  logic [28:0]     obj_mask,
  input  logic            obj_ext,
  input  logic            obj_valid,
  output logic            busy,
  output logic            done,
  output logic            hit,
  output logic [IDXW-1:0] hit_idx
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_t;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NOBJ - 1);

  state_t            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              hit_q, hit_d;
  logic [IDXW-1:0]   hit_idx_q, hit_idx_d;
  logic [28:0]       id_q, id_d;
  logic              ext_q, ext_d;
  logic              ide_ok;
  logic              obj_match;

  // Standard objects only compare the 11-bit base ID held in [28:18].
  function automatic logic id_match(input logic [28:0] oid, input logic [28:0] omask,
                                    input logic oext, input logic [28:0] rid);
    logic [28:0] diff;
    diff = (oid ^ rid) & omask;
    if (oext) return (diff == 29'd0);
    else      return (diff[28:18] == 11'd0);
  endfunction

`ifdef ACCF_IDE_MATCH_EN
  assign ide_ok = (obj_ext == ext_q);
`else
  // Frame type does not gate matching; the latched flag is kept but has no effect.
  assign ide_ok = 1'b1 | ext_q;
`endif

  assign obj_match = obj_valid & ide_ok & id_match(obj_id, obj_mask, obj_ext, id_q);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    hit_d     = hit_q;
    hit_idx_d = hit_idx_q;
    id_d      = id_q;
    ext_d     = ext_q;
    if (start) begin
      // A new frame always restarts the scan, aborting any scan in flight.
      id_d    = rx_id;
      ext_d   = rx_ext;
      idx_d   = '0;
      state_d = S_SCAN;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_SCAN: begin
          if (obj_match) begin
            hit_d     = 1'b1;
            hit_idx_d = idx_q;
            state_d   = S_DONE;
          end else if (idx_q == LAST_IDX) begin
            hit_d     = 1'b0;
            hit_idx_d = '0;
            state_d   = S_DONE;
          end else begin
            idx_d = idx_q + IDXW'(1);
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      hit_q     <= 1'b0;
      hit_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      hit_q     <= hit_d;
      hit_idx_q <= hit_idx_d;
    end
  end

  always_ff @(posedge clock) begin
    id_q  <= id_d;
    ext_q <= ext_d;
  end

  assign obj_sel = idx_q;
  assign busy    = (state_q == S_SCAN);
  assign done    = (state_q == S_DONE);
  assign hit     = hit_q;
  assign hit_idx = hit_idx_q;

endmodule
